// File: rtl/hud_score_ctrl.sv
// Per-frame HUD controller: snapshots game inputs on fsync, keeps a banked score,
// converts it to three BCD digits with a sequential double-dabble, and drives the life-lost blink.
package params;
  localparam int NUM_ROWS = 5;
  localparam int NUM_COLS = 8;
endpackage

module hud_score_ctrl #(
  parameter int FLASH_FRAMES = 32,
  parameter int TOTAL_ALIENS = params::NUM_ROWS * params::NUM_COLS,
  localparam int AW = $clog2(TOTAL_ALIENS + 1)
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          fsync,
  input  logic [1:0]    game_state,
  input  logic [AW-1:0] aliens_remaining,
  input  logic [1:0]    current_round,
  input  logic [1:0]    lives_remaining,
  output logic [11:0]   score_bcd,
  output logic [1:0]    hud_lives,
  output logic [1:0]    hud_round,
  output logic          life_flash,
  output logic          hud_valid
);

  localparam logic [1:0]    GS_IDLE   = 2'b00;
  localparam logic [1:0]    GS_PLAY   = 2'b10;
  localparam logic [AW-1:0] TOTAL_A   = AW'(TOTAL_ALIENS);
  localparam logic [10:0]   TOTAL_W   = 11'(TOTAL_ALIENS);
  localparam logic [7:0]    FLASH_LD  = 8'(FLASH_FRAMES);
  localparam logic [3:0]    LAST_ITER = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CONV    = 2'b01,
    S_PUBLISH = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] shift_q, shift_d;
  logic [3:0]  iter_q, iter_d;
  logic [9:0]  bank_q, bank_d;
  logic [7:0]  flash_cnt_q, flash_cnt_d;
  logic [1:0]  prev_round_q, prev_round_d;
  logic [1:0]  prev_lives_q, prev_lives_d;
  logic [1:0]  snap_lives_q, snap_lives_d;
  logic [1:0]  snap_round_q, snap_round_d;
  logic [11:0] score_bcd_q, score_bcd_d;
  logic [1:0]  hud_lives_q, hud_lives_d;
  logic [1:0]  hud_round_q, hud_round_d;
  logic        life_flash_q, life_flash_d;
  logic        hud_valid_q, hud_valid_d;

  logic [AW-1:0] kills;
  logic [9:0]    bank_next;
  logic [7:0]    flash_next;
  logic [9:0]    score_bin;

  function automatic logic [9:0] sat999(input logic [10:0] v);
    return (v > 11'd999) ? 10'd999 : v[9:0];
  endfunction

  // One double-dabble iteration: correct each BCD nibble, then shift the whole register.
  function automatic logic [21:0] dabble_step(input logic [21:0] s);
    logic [21:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[20:0], 1'b0};
  endfunction

  // Snapshot arithmetic; only committed when the FSM accepts fsync.
  always_comb begin
    kills = (aliens_remaining > TOTAL_A) ? '0 : (TOTAL_A - aliens_remaining);

    bank_next = bank_q;
    if (game_state == GS_IDLE) begin
      bank_next = '0;
    end else if ((game_state == GS_PLAY) && (current_round != prev_round_q)) begin
      bank_next = sat999({1'b0, bank_q} + TOTAL_W);
    end

    flash_next = flash_cnt_q;
    if (game_state == GS_IDLE) begin
      flash_next = '0;
    end else if ((game_state == GS_PLAY) && (lives_remaining < prev_lives_q)) begin
      flash_next = FLASH_LD;
    end else if (flash_cnt_q != 8'd0) begin
      flash_next = flash_cnt_q - 8'd1;
    end

    score_bin = sat999({1'b0, bank_next} + 11'(kills));
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    iter_d       = iter_q;
    bank_d       = bank_q;
    flash_cnt_d  = flash_cnt_q;
    prev_round_d = prev_round_q;
    prev_lives_d = prev_lives_q;
    snap_lives_d = snap_lives_q;
    snap_round_d = snap_round_q;
    score_bcd_d  = score_bcd_q;
    hud_lives_d  = hud_lives_q;
    hud_round_d  = hud_round_q;
    life_flash_d = life_flash_q;
    hud_valid_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fsync) begin
          bank_d       = bank_next;
          flash_cnt_d  = flash_next;
          prev_round_d = current_round;
          prev_lives_d = lives_remaining;
          snap_lives_d = lives_remaining;
          snap_round_d = current_round;
          shift_d      = {12'b0, score_bin};
          iter_d       = '0;
          state_d      = S_CONV;
        end
      end
      S_CONV: begin
        shift_d = dabble_step(shift_q);
        iter_d  = iter_q + 4'd1;
        if (iter_q == LAST_ITER) state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        score_bcd_d  = shift_q[21:10];
        hud_lives_d  = snap_lives_q;
        hud_round_d  = snap_round_q;
        life_flash_d = (flash_cnt_q != 8'd0) & flash_cnt_q[2];
        hud_valid_d  = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      iter_q       <= '0;
      bank_q       <= '0;
      flash_cnt_q  <= '0;
      prev_round_q <= '0;
      prev_lives_q <= '0;
      snap_lives_q <= '0;
      snap_round_q <= '0;
      score_bcd_q  <= '0;
      hud_lives_q  <= '0;
      hud_round_q  <= '0;
      life_flash_q <= 1'b0;
      hud_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      iter_q       <= iter_d;
      bank_q       <= bank_d;
      flash_cnt_q  <= flash_cnt_d;
      prev_round_q <= prev_round_d;
      prev_lives_q <= prev_lives_d;
      snap_lives_q <= snap_lives_d;
      snap_round_q <= snap_round_d;
      score_bcd_q  <= score_bcd_d;
      hud_lives_q  <= hud_lives_d;
      hud_round_q  <= hud_round_d;
      life_flash_q <= life_flash_d;
      hud_valid_q  <= hud_valid_d;
    end
  end

  assign score_bcd  = score_bcd_q;
  assign hud_lives  = hud_lives_q;
  assign hud_round  = hud_round_q;
  assign life_flash = life_flash_q;
  assign hud_valid  = hud_valid_q;

endmodule

// File: tb/tb_hud_score_ctrl.sv
// Scoreboard bench for hud_score_ctrl: stimulus pushes expected publishes, a monitor pops on hud_valid.
module tb_hud_score_ctrl;
  localparam int TOTAL = 40;
  localparam int FF    = 8;
  localparam int AW    = $clog2(TOTAL + 1);
  localparam logic [1:0] PLAY = 2'b10;
  localparam logic [1:0] IDLE = 2'b00;

  logic          clk = 1'b0;
  logic          rst;
  logic          fsync;
  logic [1:0]    game_state;
  logic [AW-1:0] aliens_remaining;
  logic [1:0]    current_round;
  logic [1:0]    lives_remaining;
  logic [11:0]   score_bcd;
  logic [1:0]    hud_lives;
  logic [1:0]    hud_round;
  logic          life_flash;
  logic          hud_valid;

  always #5 clk = ~clk;

  hud_score_ctrl #(.FLASH_FRAMES(FF), .TOTAL_ALIENS(TOTAL)) dut (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .game_state(game_state),
    .aliens_remaining(aliens_remaining), .current_round(current_round),
    .lives_remaining(lives_remaining), .score_bcd(score_bcd), .hud_lives(hud_lives),
    .hud_round(hud_round), .life_flash(life_flash), .hud_valid(hud_valid)
  );

  typedef struct packed {
    logic [11:0] bcd;
    logic [1:0]  lives;
    logic [1:0]  rnd;
    logic        flash;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (hud_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_hud_valid actual score=%03h required=no publish", score_bcd);
      end else begin
        mon_e = q.pop_front();
        chk("score_bcd", int'(score_bcd), int'(mon_e.bcd));
        chk("hud_lives", int'(hud_lives), int'(mon_e.lives));
        chk("hud_round", int'(hud_round), int'(mon_e.rnd));
        chk("life_flash", int'(life_flash), int'(mon_e.flash));
      end
    end
  end

  task automatic send(input logic [1:0] gs, input int al, input logic [1:0] rd, input logic [1:0] lv);
    game_state       = gs;
    aliens_remaining = AW'(al);
    current_round    = rd;
    lives_remaining  = lv;
    fsync            = 1'b1;
    @(negedge clk);
    fsync            = 1'b0;
  endtask

  task automatic expect_pub(input int score, input logic [1:0] lv, input logic [1:0] rd, input logic fl);
    exp_t e;
    e.bcd   = to_bcd(score);
    e.lives = lv;
    e.rnd   = rd;
    e.flash = fl;
    q.push_back(e);
  endtask

  task automatic drain();
    chk("publish_missing", q.size(), 0);
    q.delete();
  endtask

  task automatic frame(input logic [1:0] gs, input int al, input logic [1:0] rd,
                       input logic [1:0] lv, input int score, input logic fl);
    expect_pub(score, lv, rd, fl);
    send(gs, al, rd, lv);
    repeat (12) @(negedge clk);
    drain();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_score_bcd"}, int'(score_bcd), 0);
    chk({tag, "_hud_lives"}, int'(hud_lives), 0);
    chk({tag, "_hud_round"}, int'(hud_round), 0);
    chk({tag, "_life_flash"}, int'(life_flash), 0);
    chk({tag, "_hud_valid"}, int'(hud_valid), 0);
  endtask

  logic [1:0] rd;
  int bank;
  logic flash_pat [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; fsync = 1'b0; game_state = IDLE;
    aliens_remaining = '0; current_round = '0; lives_remaining = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("reset");

    // First frame: outputs stay at 0 until the publish edge
    expect_pub(17, 2'd3, 2'd0, 1'b0);
    send(PLAY, TOTAL - 17, 2'd0, 2'd3);
    repeat (10) @(negedge clk);
    chk("pre_publish_valid", int'(hud_valid), 0);
    chk("pre_publish_score", int'(score_bcd), 0);
    repeat (2) @(negedge clk);
    drain();

    // Round banking
    frame(PLAY, 40, 2'd1, 2'd3, 40, 1'b0);
    frame(PLAY, 35, 2'd1, 2'd3, 45, 1'b0);
    frame(PLAY, 40, 2'd2, 2'd3, 80, 1'b0);
    // Out-of-range alien count gives zero kills
    frame(PLAY, 63, 2'd2, 2'd3, 80, 1'b0);
    frame(PLAY, 50, 2'd3, 2'd3, 120, 1'b0);

    // Life lost: counter loads 8, then 7..0
    frame(PLAY, 40, 2'd3, 2'd2, 120, 1'b0);
    for (int i = 0; i < 9; i++) frame(PLAY, 40, 2'd3, 2'd2, 120, flash_pat[i]);

    // Second life loss, then START clears flash and bank
    frame(PLAY, 40, 2'd3, 2'd1, 120, 1'b0);
    frame(PLAY, 40, 2'd3, 2'd1, 120, 1'b1);
    frame(IDLE, 30, 2'd3, 2'd1, 10, 1'b0);

    // Round wrap 3 -> 0 still banks
    frame(PLAY, 40, 2'd0, 2'd1, 40, 1'b0);

    // fsync during conversion is ignored
    expect_pub(47, 2'd1, 2'd0, 1'b0);
    send(PLAY, 33, 2'd0, 2'd1);
    repeat (4) @(negedge clk);
    send(PLAY, 0, 2'd1, 2'd1);
    repeat (11) @(negedge clk);
    drain();
    frame(PLAY, 40, 2'd0, 2'd1, 40, 1'b0);

    // Reset mid-conversion aborts without a publish
    send(PLAY, 0, 2'd1, 2'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("abort");
    repeat (12) @(negedge clk);
    drain();
    frame(PLAY, 38, 2'd0, 2'd3, 2, 1'b0);

    // Saturation at 999
    rd = 2'd0;
    bank = 0;
    for (int k = 1; k <= 25; k++) begin
      rd = rd + 2'd1;
      bank = (bank + TOTAL > 999) ? 999 : bank + TOTAL;
      frame(PLAY, 40, rd, 2'd3, bank, 1'b0);
    end
    frame(PLAY, 0, rd, 2'd3, 999, 1'b0);
    rd = rd + 2'd1;
    frame(PLAY, 0, rd, 2'd3, 999, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
